ibex_trace_buffer: RTL and testbench
====================================

# ibex_trace_buffer

Parametrised retirement-trace capture buffer for the ibex core. It sits beside the core on the RVFI retirement port and records one entry per retired instruction into a circular buffer of `Depth` entries. Capture supports one-shot and wrap-with-trigger modes, with a configurable post-trigger window. After capture stops, a valid/ready stream drains the stored records oldest-first, so traces can be read back on silicon/FPGA without a simulation tracer.

## Interface
Parameters:
- `Depth`, 16, number of entries; power of two, at least 2.
- `PostTrigger`, 8, number of entries recorded after the trigger entry in wrap mode; range 0..Depth-1.
- `CntW`, $clog2(Depth)+1, derived width of `count_o`; not overridden.

Ports:
- `clk_i` input 1: single clock.
- `rst_i` input 1: synchronous, active-high reset.
- `rvfi_valid_i` input 1: instruction retired this cycle.
- `rvfi_pc_rdata_i` input 32: PC of the retired instruction.
- `rvfi_insn_i` input 32: instruction word.
- `rvfi_rd_addr_i` input 5: destination register.
- `rvfi_rd_wdata_i` input 32: destination write data.
- `rvfi_trap_i` input 1: retirement trapped.
- `rvfi_intr_i` input 1: first instruction of a trap handler.
- `arm_i` input 1: single-cycle pulse that clears the buffer and starts capture.
- `mode_i` input 1: 0 = one-shot, 1 = wrap; sampled only on `arm_i`.
- `trig_en_i` input 1: enables the PC-match trigger.
- `trig_pc_i` input 32: trigger PC.
- `state_o` output 2: 0 IDLE, 1 CAPTURE, 2 POST, 3 DONE.
- `count_o` output CntW: number of valid entries held.
- `trig_o` output 1: sticky, set when a trigger has occurred since the last arm.
- `rd_valid_o` output 1: readout entry available.
- `rd_ready_i` input 1: readout consumer accepts the entry.
- `rd_data_o` output 103: record `{trap, intr, rd_addr[4:0], pc[31:0], insn[31:0], rd_wdata[31:0]}`, MSB first.
- `rd_last_o` output 1: the current readout entry is the final one.

## Operation
- Reset: `state_o`=IDLE, `count_o`=0, `trig_o`=0, `rd_valid_o`=0, `rd_last_o`=0, `rd_data_o`=0. Write pointer and post counter reset to 0. Buffer storage is not reset.
- Trigger condition: `rvfi_valid_i & (rvfi_trap_i | (trig_en_i & rvfi_pc_rdata_i == trig_pc_i))`.
- IDLE: no capture. `arm_i` → CAPTURE, with write pointer=0, count=0, `trig_o`=0, and the mode latched.
- CAPTURE, both modes: each `rvfi_valid_i` writes one record at the write pointer. The pointer increments modulo Depth. Count increments, saturating at Depth.
- CAPTURE, one-shot: a write that makes count=Depth → DONE. A trigger only sets `trig_o`.
- CAPTURE, wrap: once full, new writes overwrite the oldest entry. A trigger entry is written and sets `trig_o`. It then → POST with post counter=PostTrigger, or → DONE directly if PostTrigger=0.
- POST: each write decrements the post counter. The write that takes it to 0 → DONE. Further triggers only keep `trig_o` set.
- DONE: no writes; RVFI is ignored.
  - `rd_valid_o` = (count>0).
  - `rd_data_o` = entry at (write pointer − count) mod Depth, combinational from storage, and forced to 0 when `rd_valid_o`=0.
  - `rd_last_o` = `rd_valid_o` & (count==1).
  - Each cycle with `rd_valid_o & rd_ready_i` decrements count.
  - At count=0 the block stays in DONE.
- `rd_ready_i` is ignored outside DONE. `rd_valid_o` is 0 outside DONE.
- `arm_i` in any state restarts capture as in IDLE, aborting any capture or readout.
- `arm_i` together with `rvfi_valid_i`: arm wins; that retirement is not recorded.
- `rst_i` mid-operation: immediate return to reset values; held contents are discarded (count=0).

## Timing
- All state, pointer, count and flag updates are registered on the rising edge of `clk_i`.
- Write latency: a record presented in cycle N is stored at edge N. `count_o` reflects it in cycle N+1.
- The transition to DONE happens on the same edge as the final write. `rd_valid_o` is high in the next cycle.
- Readout: one entry per cycle with `rd_ready_i` held high. Under backpressure, `rd_data_o`, `rd_valid_o` and `rd_last_o` stay stable.
- Full throughput: back-to-back `rvfi_valid_i` every cycle is captured with no drops.

## Test plan
- One-shot, Depth=4: arm with mode 0, then 6 retirements at PC 0x100, 0x104, … → DONE after 0x10C, count 4. Readout gives 0x100, 0x104, 0x108, 0x10C; `rd_last_o` is high only on 0x10C; `trig_o`=0.
- Wrap with PC trigger, Depth=4, PostTrigger=2, `trig_pc_i`=0x114: retirements from 0x100 in steps of 4 → DONE after 0x11C, `trig_o`=1. Readout gives 0x110, 0x114, 0x118, 0x11C.
- Wrap with trap trigger, PostTrigger=0: `rvfi_trap_i` on the 3rd retirement → DONE immediately, count 3. The first field of the last entry is 1.
- Backpressure: in DONE with count 4, hold `rd_ready_i` low for 3 cycles → data stable and count stays 4. Then hold it high → 4 pops over 4 cycles, ending with count 0 and `rd_valid_o`=0.
- Simultaneous and abort cases:
  - `arm_i` with `rvfi_valid_i` in the same cycle → count stays 0 next cycle.
  - `arm_i` in DONE after 2 pops → CAPTURE with count 0.
  - `rst_i` in POST → IDLE, all outputs at reset values.

Source files
------------

// File: rtl/ibex_trace_buffer.sv
// Retirement-trace capture buffer for the ibex RVFI port: circular record store with
// one-shot / wrap-with-trigger capture and an oldest-first valid/ready readout stream.
module ibex_trace_buffer #(
    parameter int unsigned Depth       = 16,
    parameter int unsigned PostTrigger = 8,
    parameter int unsigned CntW        = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rvfi_valid_i,
    input  logic [31:0]     rvfi_pc_rdata_i,
    input  logic [31:0]     rvfi_insn_i,
    input  logic [4:0]      rvfi_rd_addr_i,
    input  logic [31:0]     rvfi_rd_wdata_i,
    input  logic            rvfi_trap_i,
    input  logic            rvfi_intr_i,
    input  logic            arm_i,
    input  logic            mode_i,
    input  logic            trig_en_i,
    input  logic [31:0]     trig_pc_i,
    output logic [1:0]      state_o,
    output logic [CntW-1:0] count_o,
    output logic            trig_o,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [102:0]    rd_data_o,
    output logic            rd_last_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned RW = 103;

    localparam logic [CntW-1:0] L_DEPTH    = CntW'(Depth);
    localparam logic [CntW-1:0] L_DEPTH_M1 = CntW'(Depth - 32'd1);
    localparam logic [CntW-1:0] L_CNT_ZERO = CntW'(1'b0);
    localparam logic [CntW-1:0] L_CNT_ONE  = CntW'(1'b1);
    localparam logic [AW-1:0]   L_PTR_ZERO = AW'(1'b0);
    localparam logic [AW-1:0]   L_PTR_ONE  = AW'(1'b1);
    localparam logic [PW-1:0]   L_POST     = PW'(PostTrigger);
    localparam logic [PW-1:0]   L_POST_ZERO = PW'(1'b0);
    localparam logic [PW-1:0]   L_POST_ONE = PW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic [RW-1:0] f_pack(
        input logic        trap,
        input logic        intr,
        input logic [4:0]  rd_addr,
        input logic [31:0] pc,
        input logic [31:0] insn,
        input logic [31:0] wdata
    );
        return {trap, intr, rd_addr, pc, insn, wdata};
    endfunction

    state_e          r_state;
    logic [AW-1:0]   r_wptr;
    logic [CntW-1:0] r_count;
    logic [PW-1:0]   r_post;
    logic            r_trig;
    logic            r_mode;
    logic [RW-1:0]   r_mem [Depth];

    state_e          w_state_nxt;
    logic [AW-1:0]   w_wptr_nxt;
    logic [CntW-1:0] w_count_nxt;
    logic [PW-1:0]   w_post_nxt;
    logic            w_trig_nxt;
    logic            w_mode_nxt;
    logic            w_we;
    logic            w_trig_hit;
    logic [CntW-1:0] w_count_inc;
    logic [AW-1:0]   w_rd_idx;
    logic            w_rd_valid;
    logic [RW-1:0]   w_rec;

    assign w_trig_hit  = rvfi_valid_i &
                         (rvfi_trap_i | (trig_en_i & (rvfi_pc_rdata_i == trig_pc_i)));
    assign w_count_inc = (r_count == L_DEPTH) ? L_DEPTH : (r_count + L_CNT_ONE);
    assign w_rec       = f_pack(rvfi_trap_i, rvfi_intr_i, rvfi_rd_addr_i,
                                rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i);
    // Oldest entry sits count slots behind the write pointer; a full buffer wraps onto it.
    assign w_rd_idx    = r_wptr - r_count[AW-1:0];
    assign w_rd_valid  = (r_state == ST_DONE) && (r_count != L_CNT_ZERO);

    // Next-state, pointer, counter and write-enable decode.
    always_comb begin
        w_state_nxt = r_state;
        w_wptr_nxt  = r_wptr;
        w_count_nxt = r_count;
        w_post_nxt  = r_post;
        w_trig_nxt  = r_trig;
        w_mode_nxt  = r_mode;
        w_we        = 1'b0;
        if (arm_i) begin
            w_state_nxt = ST_CAPTURE;
            w_wptr_nxt  = L_PTR_ZERO;
            w_count_nxt = L_CNT_ZERO;
            w_post_nxt  = L_POST_ZERO;
            w_trig_nxt  = 1'b0;
            w_mode_nxt  = mode_i;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_CAPTURE: begin
                    if (rvfi_valid_i) begin
                        w_we        = 1'b1;
                        w_wptr_nxt  = r_wptr + L_PTR_ONE;
                        w_count_nxt = w_count_inc;
                        if (w_trig_hit) begin
                            w_trig_nxt = 1'b1;
                        end else begin
                            w_trig_nxt = r_trig;
                        end
                        if (!r_mode) begin
                            if (r_count == L_DEPTH_M1) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_state_nxt = ST_CAPTURE;
                            end
                        end else if (w_trig_hit) begin
                            if (PostTrigger == 32'd0) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_state_nxt = ST_POST;
                                w_post_nxt  = L_POST;
                            end
                        end else begin
                            w_state_nxt = ST_CAPTURE;
                        end
                    end else begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                ST_POST: begin
                    if (rvfi_valid_i) begin
                        w_we        = 1'b1;
                        w_wptr_nxt  = r_wptr + L_PTR_ONE;
                        w_count_nxt = w_count_inc;
                        w_post_nxt  = r_post - L_POST_ONE;
                        if (w_trig_hit) begin
                            w_trig_nxt = 1'b1;
                        end else begin
                            w_trig_nxt = r_trig;
                        end
                        if (r_post == L_POST_ONE) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_POST;
                        end
                    end else begin
                        w_state_nxt = ST_POST;
                    end
                end
                ST_DONE: begin
                    if (w_rd_valid && rd_ready_i) begin
                        w_count_nxt = r_count - L_CNT_ONE;
                    end else begin
                        w_count_nxt = r_count;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_wptr  <= L_PTR_ZERO;
            r_count <= L_CNT_ZERO;
            r_post  <= L_POST_ZERO;
            r_trig  <= 1'b0;
            r_mode  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wptr  <= w_wptr_nxt;
            r_count <= w_count_nxt;
            r_post  <= w_post_nxt;
            r_trig  <= w_trig_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Record storage; contents are intentionally not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (w_we && !rst_i) begin
            r_mem[r_wptr] <= w_rec;
        end
    end

    // Readout stream, held at zero whenever no entry is offered.
    always_comb begin
        rd_valid_o = w_rd_valid;
        if (w_rd_valid) begin
            rd_data_o = r_mem[w_rd_idx];
            rd_last_o = (r_count == L_CNT_ONE);
        end else begin
            rd_data_o = {RW{1'b0}};
            rd_last_o = 1'b0;
        end
    end

    assign state_o = r_state;
    assign count_o = r_count;
    assign trig_o  = r_trig;

endmodule

// File: tb/tb_ibex_trace_buffer.sv
// Directed bench for ibex_trace_buffer: instance A (Depth 4, post window 2) and
// instance B (Depth 4, no post window) share the RVFI stimulus.
module tb_ibex_trace_buffer;

    logic         clk = 1'b0;
    logic         rst;
    logic         rvfi_valid;
    logic [31:0]  pc;
    logic [31:0]  insn;
    logic [4:0]   rd_addr;
    logic [31:0]  wdata;
    logic         trap;
    logic         intr;
    logic         arm_a;
    logic         arm_b;
    logic         mode;
    logic         trig_en;
    logic [31:0]  trig_pc;
    logic         rd_ready;

    logic [1:0]   state_a, state_b;
    logic [2:0]   count_a, count_b;
    logic         trig_a, trig_b;
    logic         rd_valid_a, rd_valid_b;
    logic [102:0] rd_data_a, rd_data_b;
    logic         rd_last_a, rd_last_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ibex_trace_buffer #(.Depth(4), .PostTrigger(2)) u_a (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(rvfi_valid), .rvfi_pc_rdata_i(pc),
        .rvfi_insn_i(insn), .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(wdata),
        .rvfi_trap_i(trap), .rvfi_intr_i(intr), .arm_i(arm_a), .mode_i(mode),
        .trig_en_i(trig_en), .trig_pc_i(trig_pc), .state_o(state_a), .count_o(count_a),
        .trig_o(trig_a), .rd_valid_o(rd_valid_a), .rd_ready_i(rd_ready),
        .rd_data_o(rd_data_a), .rd_last_o(rd_last_a)
    );

    ibex_trace_buffer #(.Depth(4), .PostTrigger(0)) u_b (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(rvfi_valid), .rvfi_pc_rdata_i(pc),
        .rvfi_insn_i(insn), .rvfi_rd_addr_i(rd_addr), .rvfi_rd_wdata_i(wdata),
        .rvfi_trap_i(trap), .rvfi_intr_i(intr), .arm_i(arm_b), .mode_i(mode),
        .trig_en_i(trig_en), .trig_pc_i(trig_pc), .state_o(state_b), .count_o(count_b),
        .trig_o(trig_b), .rd_valid_o(rd_valid_b), .rd_ready_i(rd_ready),
        .rd_data_o(rd_data_b), .rd_last_o(rd_last_b)
    );

    // Record for retirement number idx: PC 0x100 + 4*idx.
    function automatic logic [102:0] rec(input int idx, input logic tr);
        logic [31:0] p;
        p = 32'h100 + 32'(idx * 4);
        return {tr, 1'b0, 5'(idx), p, 32'hA000_0000 | 32'(idx), 32'h5000_0000 | 32'(idx)};
    endfunction

    task automatic chk(input string tag, input logic [102:0] obs, input logic [102:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input int idx, input logic tr);
        pc         = 32'h100 + 32'(idx * 4);
        insn       = 32'hA000_0000 | 32'(idx);
        rd_addr    = 5'(idx);
        wdata      = 32'h5000_0000 | 32'(idx);
        trap       = tr;
        rvfi_valid = 1'b1;
        tick();
        rvfi_valid = 1'b0;
        trap       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rvfi_valid = 1'b0; pc = 32'h0; insn = 32'h0; rd_addr = 5'h0;
        wdata = 32'h0; trap = 1'b0; intr = 1'b0; arm_a = 1'b0; arm_b = 1'b0;
        mode = 1'b0; trig_en = 1'b0; trig_pc = 32'h0; rd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_state", state_a, 103'd0);
        chk("rst_count", count_a, 103'd0);
        chk("rst_trig", trig_a, 103'd0);
        chk("rst_valid", rd_valid_a, 103'd0);
        chk("rst_last", rd_last_a, 103'd0);
        chk("rst_data", rd_data_a, 103'd0);

        // One-shot capture of 6 retirements into a 4-entry buffer
        mode = 1'b0; arm_a = 1'b1; tick(); arm_a = 1'b0;
        chk("os_arm_state", state_a, 103'd1);
        chk("os_arm_count", count_a, 103'd0);
        for (int i = 0; i < 4; i++) retire(i, 1'b0);
        chk("os_done_state", state_a, 103'd3);
        chk("os_done_count", count_a, 103'd4);
        retire(4, 1'b0);
        retire(5, 1'b0);
        chk("os_ign_count", count_a, 103'd4);
        chk("os_trig", trig_a, 103'd0);
        chk("os_valid", rd_valid_a, 103'd1);
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("os_rd_pc", rd_data_a[95:64], 103'(32'h100 + 32'(k * 4)));
            chk("os_rd_rec", rd_data_a, rec(k, 1'b0));
            chk("os_rd_last", rd_last_a, 103'(k == 3));
            tick();
        end
        rd_ready = 1'b0;
        chk("os_end_count", count_a, 103'd0);
        chk("os_end_valid", rd_valid_a, 103'd0);
        chk("os_end_data", rd_data_a, 103'd0);
        chk("os_end_state", state_a, 103'd3);

        // Wrap mode with PC trigger at 0x114, two post-trigger entries
        mode = 1'b1; trig_en = 1'b1; trig_pc = 32'h114;
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        chk("wr_arm_count", count_a, 103'd0);
        for (int i = 0; i < 6; i++) retire(i, 1'b0);
        chk("wr_post_state", state_a, 103'd2);
        chk("wr_post_trig", trig_a, 103'd1);
        chk("wr_post_count", count_a, 103'd4);
        retire(6, 1'b0);
        chk("wr_post2_state", state_a, 103'd2);
        retire(7, 1'b0);
        chk("wr_done_state", state_a, 103'd3);
        chk("wr_done_count", count_a, 103'd4);
        retire(8, 1'b0);
        chk("wr_ign_count", count_a, 103'd4);
        trig_en = 1'b0;

        // Backpressure: outputs hold while rd_ready is low
        for (int c = 0; c < 3; c++) begin
            chk("bp_pc", rd_data_a[95:64], 103'(32'h110));
            chk("bp_rec", rd_data_a, rec(4, 1'b0));
            chk("bp_count", count_a, 103'd4);
            chk("bp_valid", rd_valid_a, 103'd1);
            chk("bp_last", rd_last_a, 103'd0);
            tick();
        end
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("wr_rd_pc", rd_data_a[95:64], 103'(32'h110 + 32'(k * 4)));
            chk("wr_rd_rec", rd_data_a, rec(4 + k, 1'b0));
            chk("wr_rd_last", rd_last_a, 103'(k == 3));
            tick();
        end
        rd_ready = 1'b0;
        chk("wr_end_count", count_a, 103'd0);
        chk("wr_end_valid", rd_valid_a, 103'd0);

        // Wrap mode, trap trigger, no post window (instance B)
        mode = 1'b1; arm_b = 1'b1; tick(); arm_b = 1'b0;
        retire(0, 1'b0);
        retire(1, 1'b0);
        chk("tp_mid_state", state_b, 103'd1);
        retire(2, 1'b1);
        chk("tp_state", state_b, 103'd3);
        chk("tp_count", count_b, 103'd3);
        chk("tp_trig", trig_b, 103'd1);
        chk("tp_first", rd_data_b, rec(0, 1'b0));
        rd_ready = 1'b1;
        tick();
        tick();
        chk("tp_last_flag", rd_last_b, 103'd1);
        chk("tp_last_trap", rd_data_b[102], 103'd1);
        chk("tp_last_rec", rd_data_b, rec(2, 1'b1));
        tick();
        rd_ready = 1'b0;
        chk("tp_end_count", count_b, 103'd0);

        // Arm together with a retirement: the retirement is dropped
        mode = 1'b0; arm_a = 1'b1; pc = 32'h200; rvfi_valid = 1'b1; tick();
        arm_a = 1'b0; rvfi_valid = 1'b0;
        chk("ar_state", state_a, 103'd1);
        chk("ar_count", count_a, 103'd0);
        tick();
        chk("ar_count2", count_a, 103'd0);

        // Re-arm in DONE after two pops
        for (int i = 0; i < 4; i++) retire(i, 1'b0);
        chk("ab_full", count_a, 103'd4);
        rd_ready = 1'b1; tick(); tick(); rd_ready = 1'b0;
        chk("ab_count2", count_a, 103'd2);
        chk("ab_head", rd_data_a[95:64], 103'(32'h108));
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        chk("ab_state", state_a, 103'd1);
        chk("ab_count", count_a, 103'd0);
        chk("ab_valid", rd_valid_a, 103'd0);

        // Reset while in POST
        mode = 1'b1; trig_en = 1'b1; trig_pc = 32'h104;
        arm_a = 1'b1; tick(); arm_a = 1'b0;
        retire(0, 1'b0);
        retire(1, 1'b0);
        chk("rp_state", state_a, 103'd2);
        chk("rp_trig", trig_a, 103'd1);
        chk("rp_count", count_a, 103'd2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rp_r_state", state_a, 103'd0);
        chk("rp_r_count", count_a, 103'd0);
        chk("rp_r_trig", trig_a, 103'd0);
        chk("rp_r_valid", rd_valid_a, 103'd0);
        chk("rp_r_last", rd_last_a, 103'd0);
        chk("rp_r_data", rd_data_a, 103'd0);
        chk("rp_b_state", state_b, 103'd0);
        chk("rp_b_trig", trig_b, 103'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
